// File: rtl/rbm_visible_recon.sv
// RBM hidden->visible reconstruction: serial MAC per visible unit, sigmoid, LFSR sampling.
// Optional probability output port enabled by defining RBM_RECON_PROB_OUT_EN.

module rbm_recon_sigmoid #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  s,
  output logic [OUT_W-1:0] p
);
  // Monotone linear map of the full signed range onto [0, 2^OUT_W-1]:
  // flipping the sign bit turns two's complement into offset binary.
  logic [IN_W-1:0] ofs;
  assign ofs = {~s[IN_W-1], s[IN_W-2:0]};

  if (OUT_W <= IN_W) begin : g_trunc
    assign p = OUT_W'(ofs >> (IN_W - OUT_W));
  end else begin : g_pad
    assign p = {ofs, {(OUT_W - IN_W){1'b0}}};
  end
endmodule

module rbm_visible_recon #(
  parameter int          data_bitlength = 12,
  parameter int          sg_bitlength   = 8,
  parameter int          vis_dim        = 6,
  parameter int          hid_dim        = 5,
  parameter logic [15:0] lfsr_seed      = 16'hACE1
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [hid_dim-1:0]                        HiddenI,
  input  logic [vis_dim*hid_dim*data_bitlength-1:0] WeightI,
  input  logic [vis_dim*data_bitlength-1:0]         BiasI,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [vis_dim-1:0]                        VoutputO,
`ifdef RBM_RECON_PROB_OUT_EN
  output logic [vis_dim*sg_bitlength-1:0]           ProbO,
`endif
  output logic [1:0]                                dbg_state
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends combinationally on ready, and the payload is held while valid waits.
  localparam int DW = data_bitlength;
  localparam int AW = DW + $clog2(hid_dim) + 1;
  localparam int IW = (vis_dim > 1) ? $clog2(vis_dim) : 1;
  localparam int JW = (hid_dim > 1) ? $clog2(hid_dim) : 1;
  localparam logic [15:0] SEED = (lfsr_seed == 16'd0) ? 16'h0001 : lfsr_seed;
  localparam logic signed [AW-1:0] SMAX = AW'((2 ** (DW - 1)) - 1);
  localparam logic signed [AW-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, ACT = 2'd2, DONE = 2'd3} state_t;

  state_t               state, state_next;
  logic [hid_dim-1:0]   h_q;
  logic signed [AW-1:0] acc;
  logic [IW-1:0]        i_cnt;
  logic [JW-1:0]        j_cnt;
  logic [15:0]          lfsr;
  logic [vis_dim-1:0]   vout;

  logic [DW-1:0]           w_sel, b_sel, s_sat;
  logic signed [AW-1:0]    w_ext, b_ext, s_sum;
  logic [sg_bitlength-1:0] p_val, rnd;
  logic                    v_bit, lfsr_fb;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ACC;
      end
      ACC:  if (j_cnt == JW'(hid_dim - 1)) state_next = ACT;
      ACT:  state_next = (i_cnt == IW'(vis_dim - 1)) ? DONE : ACC;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign dbg_state = state;
  assign VoutputO  = vout;

  // Weights and biases are read live from the bus; the source holds them for the whole pass.
  assign w_sel = WeightI[(int'(i_cnt) * hid_dim + int'(j_cnt)) * DW +: DW];
  assign b_sel = BiasI[int'(i_cnt) * DW +: DW];
  assign w_ext = {{(AW - DW){w_sel[DW-1]}}, w_sel};
  assign b_ext = {{(AW - DW){b_sel[DW-1]}}, b_sel};
  assign s_sum = acc + b_ext;

  always_comb begin
    s_sat = s_sum[DW-1:0];
    if (s_sum > SMAX)      s_sat = SMAX[DW-1:0];
    else if (s_sum < SMIN) s_sat = SMIN[DW-1:0];
  end

  rbm_recon_sigmoid #(.IN_W(DW), .OUT_W(sg_bitlength)) u_sigmoid (
    .s (s_sat),
    .p (p_val)
  );

  assign rnd     = lfsr[15 -: sg_bitlength];
  assign v_bit   = p_val > rnd;
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clock) begin
    if (reset) begin
      h_q   <= '0;
      acc   <= '0;
      i_cnt <= '0;
      j_cnt <= '0;
      lfsr  <= SEED;
      vout  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          h_q   <= HiddenI;
          acc   <= '0;
          i_cnt <= '0;
          j_cnt <= '0;
        end
        ACC: begin
          if (h_q[j_cnt]) acc <= acc + w_ext;
          j_cnt <= j_cnt + 1'b1;
        end
        ACT: begin
          vout[i_cnt] <= v_bit;
          lfsr        <= {lfsr[14:0], lfsr_fb};
          acc         <= '0;
          j_cnt       <= '0;
          i_cnt       <= i_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef RBM_RECON_PROB_OUT_EN
  logic [vis_dim*sg_bitlength-1:0] prob;

  always_ff @(posedge clock) begin
    if (reset)             prob <= '0;
    else if (state == ACT) prob[int'(i_cnt) * sg_bitlength +: sg_bitlength] <= p_val;
  end

  assign ProbO = prob;
`endif
endmodule
